// File: rtl/fetch_pc.sv
// ---------------------------------------------------------------------------
// fetch_pc -- instruction-fetch PC generator for the five-stage RV32I core.
//
// Sits upstream of the branch predictor (pdt) and the IF/ID latch. It issues
// one instruction-memory request at a time and presents each returned
// instruction on if_pc/if_inst/if_valid. It then chooses the next fetch
// address. Mispredict redirects from ID and stalls from ctrl steer it.
//
// Optional feature macro: FETCH_PDT_EN
//   defined   : next PC = branch_or_not ? pdt_pc : if_pc + 4
//   undefined : next PC = if_pc + 4; branch_or_not/pdt_pc are ignored.
//   Both builds have the same port list.
//
// Parameters
//   RESET_PC        first fetch address after reset
//   NOP_INST        value on if_inst while nothing live is presented
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   stall           ctrl stall: freezes the IF outputs and the next-PC choice
//   branch_or_not   predictor: the presented instruction is a taken branch
//   pdt_pc          predictor: predicted next PC
//   id_redirect     one-cycle pulse from ID on a misprediction
//   id_redirect_pc  correct PC. It is valid with id_redirect and is
//                   word-aligned here.
//   mem_req         fetch request to instruction memory
//   mem_addr        fetch address; held stable while mem_req is high
//   mem_ack         one-cycle acknowledge; mem_rdata is valid in that cycle
//   mem_rdata       fetched instruction
//   if_pc           PC of the presented instruction
//   if_inst         presented instruction (NOP_INST when not live)
//   if_valid        if_pc/if_inst hold a live instruction
//
// Memory handshake: the request is a level, not a pulse. Once mem_req rises,
// mem_req and mem_addr stay constant until the cycle in which mem_ack is
// sampled high. mem_req drops on the following edge. At most one request is
// outstanding, and any mem_ack outside WAIT/DISCARD is ignored.
//
// The FSM state is the internal signal 'state' (type state_t).
// ---------------------------------------------------------------------------
module fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_or_not,
    input  logic [31:0] pdt_pc,
    input  logic        id_redirect,
    input  logic [31:0] id_redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,  // raise mem_req at mem_addr on the next edge
        ST_WAIT    = 2'd1,  // request outstanding, waiting for mem_ack
        ST_DISCARD = 2'd2,  // outstanding request is stale, drop its data
        ST_PRESENT = 2'd3   // instruction (or skid contents) being presented
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        mem_req_next;
    logic [31:0] mem_addr_next;
    logic [31:0] if_pc_next;
    logic [31:0] if_inst_next;
    logic        if_valid_next;

    // One-entry skid buffer. It holds a response that arrived while stalled.
    logic        skid_valid;
    logic        skid_valid_next;
    logic [31:0] skid_pc;
    logic [31:0] skid_pc_next;
    logic [31:0] skid_inst;
    logic [31:0] skid_inst_next;

    // Redirect target. It is held while a stale request drains in DISCARD.
    logic [31:0] redir_pc;
    logic [31:0] redir_pc_next;

    // ISSUE was entered by a redirect. Such an issue is not held off by stall.
    // Without this, a redirect that arrives during a long stall would sit idle.
    logic        force_issue;
    logic        force_issue_next;

    logic [31:0] redir_aligned;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;

    assign redir_aligned = {id_redirect_pc[31:2], 2'b00};
    assign seq_pc        = if_pc + 32'd4;   // wraps modulo 2^32

`ifdef FETCH_PDT_EN
    assign next_pc = branch_or_not ? pdt_pc : seq_pc;
`else
    // Predictor inputs are not used in this build. They are folded into a
    // sink so the port list matches the predicted build.
    logic unused_pdt;
    assign unused_pdt = ^{branch_or_not, pdt_pc};
    assign next_pc    = seq_pc;
`endif

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        mem_req_next     = mem_req;
        mem_addr_next    = mem_addr;
        if_pc_next       = if_pc;
        if_inst_next     = if_inst;
        if_valid_next    = if_valid;
        skid_valid_next  = skid_valid;
        skid_pc_next     = skid_pc;
        skid_inst_next   = skid_inst;
        redir_pc_next    = redir_pc;
        force_issue_next = force_issue;

        if (id_redirect) begin
            // A redirect wins over stall and over the normal flow.
            if_valid_next   = 1'b0;
            if_inst_next    = NOP_INST;
            skid_valid_next = 1'b0;
            redir_pc_next   = redir_aligned;
            if ((state == ST_WAIT || state == ST_DISCARD) && !mem_ack) begin
                // The request is still in flight. Keep it on the bus until it
                // is acked, then throw the data away.
                state_next = ST_DISCARD;
            end else begin
                // Either nothing is outstanding, or it completes this very
                // cycle and its data is dropped.
                state_next       = ST_ISSUE;
                mem_req_next     = 1'b0;
                mem_addr_next    = redir_aligned;
                force_issue_next = 1'b1;
            end
        end else begin
            case (state)
                ST_ISSUE: begin
                    if (!stall || force_issue) begin
                        mem_req_next     = 1'b1;
                        force_issue_next = 1'b0;
                        state_next       = ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (mem_ack) begin
                        mem_req_next = 1'b0;
                        state_next   = ST_PRESENT;
                        if (stall) begin
                            skid_valid_next = 1'b1;
                            skid_pc_next    = mem_addr;
                            skid_inst_next  = mem_rdata;
                        end else begin
                            if_valid_next = 1'b1;
                            if_pc_next    = mem_addr;
                            if_inst_next  = mem_rdata;
                        end
                    end
                end

                ST_DISCARD: begin
                    if (mem_ack) begin
                        mem_req_next     = 1'b0;
                        mem_addr_next    = redir_pc;
                        force_issue_next = 1'b1;
                        state_next       = ST_ISSUE;
                    end
                end

                ST_PRESENT: begin
                    if (!stall) begin
                        if (skid_valid) begin
                            // First free cycle after a stalled capture: show
                            // the buffered instruction. Stay here so that the
                            // next-PC choice sees it.
                            if_valid_next   = 1'b1;
                            if_pc_next      = skid_pc;
                            if_inst_next    = skid_inst;
                            skid_valid_next = 1'b0;
                        end else begin
                            mem_addr_next = next_pc;
                            if_valid_next = 1'b0;
                            if_inst_next  = NOP_INST;
                            state_next    = ST_ISSUE;
                        end
                    end
                end

                default: begin
                    state_next = ST_ISSUE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ISSUE;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC;
            if_pc       <= RESET_PC;
            if_inst     <= NOP_INST;
            if_valid    <= 1'b0;
            skid_valid  <= 1'b0;
            skid_pc     <= RESET_PC;
            skid_inst   <= NOP_INST;
            redir_pc    <= RESET_PC;
            force_issue <= 1'b0;
        end else begin
            state       <= state_next;
            mem_req     <= mem_req_next;
            mem_addr    <= mem_addr_next;
            if_pc       <= if_pc_next;
            if_inst     <= if_inst_next;
            if_valid    <= if_valid_next;
            skid_valid  <= skid_valid_next;
            skid_pc     <= skid_pc_next;
            skid_inst   <= skid_inst_next;
            redir_pc    <= redir_pc_next;
            force_issue <= force_issue_next;
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc -- directed self-checking bench for fetch_pc.
// Inputs are driven, and outputs sampled, on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fetch_pc;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_or_not;
    logic [31:0] pdt_pc;
    logic        id_redirect;
    logic [31:0] id_redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    logic auto_mem = 1'b0;

    fetch_pc #(
        .RESET_PC(32'h0),
        .NOP_INST(NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_or_not (branch_or_not),
        .pdt_pc        (pdt_pc),
        .id_redirect   (id_redirect),
        .id_redirect_pc(id_redirect_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_valid      (if_valid)
    );

    // clock
    always #5 clk = ~clk;

    // instruction image: a fixed function of the address
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0003;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One cycle: step to the next falling edge. In auto mode, memory acks any
    // request that it sees there.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (auto_mem) begin
            mem_ack   = mem_req;
            mem_rdata = inst_of(mem_addr);
        end else begin
            mem_ack   = 1'b0;
        end
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!if_valid && n < max_cyc);
        check("wait_valid_timeout", {31'b0, if_valid}, 32'h1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_req"},  {31'b0, mem_req},  32'h0);
        check({tag, "_mem_addr"}, mem_addr,          32'h0);
        check({tag, "_if_valid"}, {31'b0, if_valid}, 32'h0);
        check({tag, "_if_pc"},    if_pc,             32'h0);
        check({tag, "_if_inst"},  if_inst,           NOP);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_prev;
        logic [31:0] br_exp;

        rst = 1'b1; stall = 1'b0; branch_or_not = 1'b0; pdt_pc = 32'h0;
        id_redirect = 1'b0; id_redirect_pc = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

        // ---- reset ----
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        auto_mem = 1'b1;

        // ---- sequential fetch, zero-wait memory ----
        cyc();
        check("first_req",  {31'b0, mem_req}, 32'h1);
        check("first_addr", mem_addr, 32'h0);
        wait_valid(10);
        check("seq_pc0",   if_pc,   32'h0);
        check("seq_inst0", if_inst, inst_of(32'h0));
        t_prev = cyc_n;
        wait_valid(10);
        check("seq_pc4",     if_pc,         32'h4);
        check("seq_space1",  cyc_n - t_prev, 32'd3);
        t_prev = cyc_n;
        wait_valid(10);
        check("seq_pc8",     if_pc,         32'h8);
        check("seq_space2",  cyc_n - t_prev, 32'd3);
        wait_valid(10);
        wait_valid(10);
        check("seq_pc10", if_pc, 32'h10);

        // ---- predicted branch at 0x10 ----
        branch_or_not = 1'b1;
        pdt_pc        = 32'h40;
`ifdef FETCH_PDT_EN
        br_exp = 32'h40;
`else
        br_exp = 32'h14;
`endif
        cyc();
        branch_or_not = 1'b0;
        pdt_pc        = 32'h0;
        check("branch_next_addr", mem_addr, br_exp);
        check("branch_valid_drop", {31'b0, if_valid}, 32'h0);
        auto_mem = 1'b0;

        // ---- stall for 4 cycles during WAIT, ack on 2nd stall cycle ----
        cyc();
        check("stall_wait_req", {31'b0, mem_req}, 32'h1);
        stall = 1'b1;
        cyc();
        check("stall_c1_valid", {31'b0, if_valid}, 32'h0);
        mem_ack = 1'b1; mem_rdata = inst_of(br_exp);
        cyc();
        check("stall_c2_valid", {31'b0, if_valid}, 32'h0);
        check("stall_c2_inst",  if_inst, NOP);
        check("stall_c2_req",   {31'b0, mem_req}, 32'h0);
        cyc();
        check("stall_c3_req",   {31'b0, mem_req}, 32'h0);
        cyc();
        check("stall_c4_valid", {31'b0, if_valid}, 32'h0);
        check("stall_c4_req",   {31'b0, mem_req}, 32'h0);
        stall = 1'b0;
        cyc();
        check("skid_valid", {31'b0, if_valid}, 32'h1);
        check("skid_pc",    if_pc,   br_exp);
        check("skid_inst",  if_inst, inst_of(br_exp));
        check("skid_no_req", {31'b0, mem_req}, 32'h0);

        // ---- idle redirect to a misaligned PC (0x32 -> 0x30) ----
        id_redirect = 1'b1; id_redirect_pc = 32'h32;
        cyc();
        id_redirect = 1'b0;
        check("redir_valid",  {31'b0, if_valid}, 32'h0);
        check("redir_addr",   mem_addr, 32'h30);
        cyc();
        check("redir_req",    {31'b0, mem_req}, 32'h1);
        check("redir_req_addr", mem_addr, 32'h30);

        // ---- redirect to 0x200 while WAIT at 0x30, stale ack 2 cycles later ----
        id_redirect = 1'b1; id_redirect_pc = 32'h200;
        cyc();
        id_redirect = 1'b0;
        check("discard_req_held",  {31'b0, mem_req}, 32'h1);
        check("discard_addr_held", mem_addr, 32'h30);
        cyc();
        mem_ack = 1'b1; mem_rdata = inst_of(32'h30);
        cyc();
        check("discard_valid", {31'b0, if_valid}, 32'h0);
        check("discard_next",  mem_addr, 32'h200);
        cyc();
        check("discard_new_req",  {31'b0, mem_req}, 32'h1);
        check("discard_no_stale", {31'b0, if_valid}, 32'h0);
        mem_ack = 1'b1; mem_rdata = inst_of(32'h200);
        cyc();
        check("after_discard_pc",   if_pc,   32'h200);
        check("after_discard_inst", if_inst, inst_of(32'h200));

        // ---- redirect to 0x100 together with stall in PRESENT ----
        stall = 1'b1;
        id_redirect = 1'b1; id_redirect_pc = 32'h100;
        cyc();
        id_redirect = 1'b0;
        check("rs_valid", {31'b0, if_valid}, 32'h0);
        check("rs_inst",  if_inst, NOP);
        check("rs_addr",  mem_addr, 32'h100);
        cyc();
        check("rs_req_in_stall", {31'b0, mem_req}, 32'h1);
        stall = 1'b0;
        mem_ack = 1'b1; mem_rdata = inst_of(32'h100);
        cyc();
        check("rs_pc", if_pc, 32'h100);

        // ---- wrap: 0xFFFFFFFC + 4 ----
        id_redirect = 1'b1; id_redirect_pc = 32'hFFFF_FFFC;
        cyc();
        id_redirect = 1'b0;
        cyc();
        check("wrap_req_addr", mem_addr, 32'hFFFF_FFFC);
        mem_ack = 1'b1; mem_rdata = inst_of(32'hFFFF_FFFC);
        cyc();
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        cyc();
        check("wrap_next_addr", mem_addr, 32'h0);

        // ---- rst mid-WAIT, then stray ack ----
        cyc();
        check("pre_rst_req", {31'b0, mem_req}, 32'h1);
        rst = 1'b1;
        cyc();
        check_reset_vals("midrst");
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        cyc();
        check("stray_req",   {31'b0, mem_req},  32'h1);
        check("stray_valid", {31'b0, if_valid}, 32'h0);
        cyc();
        check("stray_valid2", {31'b0, if_valid}, 32'h0);
        check("stray_req2",   {31'b0, mem_req},  32'h1);
        mem_ack = 1'b1; mem_rdata = inst_of(32'h0);
        cyc();
        check("post_rst_pc",   if_pc,   32'h0);
        check("post_rst_inst", if_inst, inst_of(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Instruction-fetch PC generator for the five-stage RV32I core. It sits directly upstream of the branch predictor `pdt` and feeds it.
- Produces `if_pc`/`if_inst` for the predictor and the IF/ID latch.
- Consumes `branch_or_not`/`pdt_pc` to choose the next fetch address.
- Runs the request/acknowledge handshake to instruction memory.
- Applies mispredict redirects from ID and pipeline stalls from ctrl.

## Interface
Parameters:
- `RESET_PC`, 32'h0, first fetch address after reset.
- `NOP_INST`, 32'h00000013, value driven on `if_inst` when invalid or flushed.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: ctrl stall; freezes IF outputs.
- `branch_or_not` in 1: predictor says the presented instruction is a branch.
- `pdt_pc` in 32: predicted next PC from the predictor.
- `id_redirect` in 1: one-cycle pulse; ID detected a misprediction.
- `id_redirect_pc` in 32: correct PC, valid with `id_redirect`.
- `mem_req` out 1: fetch request.
- `mem_addr` out 32: fetch address; stable while `mem_req`=1.
- `mem_ack` in 1: one-cycle pulse; `mem_rdata` valid in that cycle.
- `mem_rdata` in 32: fetched instruction.
- `if_pc` out 32: PC of the presented instruction.
- `if_inst` out 32: presented instruction.
- `if_valid` out 1: `if_pc`/`if_inst` hold a live instruction.

## Operation
- Reset values:
  - `mem_req`=0, `mem_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=`RESET_PC`, `if_inst`=`NOP_INST`.
  - Skid buffer empty; state ISSUE.
- States:
  - ISSUE: drive `mem_req`=1 at `mem_addr` next cycle; go to WAIT.
  - WAIT: hold request until `mem_ack`.
  - DISCARD: outstanding request is stale; wait for `mem_ack`, drop its data, then go to ISSUE at the pending redirect PC.
  - PRESENT: instruction on `if_*`; compute next PC.
- Fetch flow:
  - `mem_ack` in WAIT: capture `mem_addr`/`mem_rdata` into `if_pc`/`if_inst` with `if_valid`=1, then go to PRESENT.
  - If `stall`=1 in that cycle, capture into the 1-entry skid buffer instead. `if_*` are frozen and move to the buffer contents on the first non-stalled cycle.
- Next PC in PRESENT, with `stall`=0:
  - `branch_or_not` ? `pdt_pc` : `if_pc`+4, modulo 2^32.
  - Registered into `mem_addr`; go to ISSUE.
  - `if_valid` drops to 0 the same edge, and `if_inst`=`NOP_INST`.
- Stall:
  - `stall`=1 freezes `if_*`, state PRESENT and next-PC selection.
  - An outstanding WAIT request is not cancelled.
  - No new request is issued while `stall`=1.
- Redirect (highest priority below `rst`):
  - Next edge: `if_valid`=0, `if_inst`=`NOP_INST`, skid buffer cleared, redirect PC latched.
  - If in WAIT with no `mem_ack` that cycle: go to DISCARD.
  - If `mem_ack` in the same cycle: data dropped, go to ISSUE at redirect PC.
  - Otherwise: ISSUE at redirect PC.
  - Redirect overrides `stall`.
- A second redirect in DISCARD overwrites the pending PC.
- Redirect PCs with bits [1:0] ≠ 0 are forced to [1:0]=0.

## Timing
- Request to instruction:
  - `mem_req` rises 1 cycle after ISSUE is entered.
  - `if_valid` rises the edge after `mem_ack`.
- Minimum issue-to-issue: 3 cycles with zero-wait memory (ISSUE, WAIT+ack, PRESENT).
- Redirect to new request: 2 cycles when idle. In DISCARD: 2 cycles after the stale `mem_ack`.
- `rst` mid-request abandons the request; any later `mem_ack` before the first new request is ignored.

## Configuration
- `FETCH_PDT_EN`:
  - Defined: next PC follows `branch_or_not`/`pdt_pc` as above.
  - Undefined: `branch_or_not`/`pdt_pc` are ignored, next PC is always `if_pc`+4, and only redirects change flow.
  - Port list is identical in both builds.

## Test plan
- Reset, then memory acks in 1 cycle:
  - First `mem_addr`=0x0.
  - `if_valid` pulses with `if_pc`=0x0, then 0x4, then 0x8.
  - 3-cycle spacing.
- Predicted branch at `if_pc`=0x10 with `branch_or_not`=1, `pdt_pc`=0x40:
  - Next `mem_addr`=0x40.
  - With `FETCH_PDT_EN` undefined: 0x14.
- `stall`=1 for 4 cycles during WAIT, ack on the 2nd stall cycle:
  - Data held in skid; `if_*` unchanged during the stall.
  - Instruction presented on the first cycle after `stall`=0.
  - No extra `mem_req`.
- `id_redirect` to 0x200 while WAIT at 0x30, ack 2 cycles later:
  - Data for 0x30 is never presented.
  - Next `mem_addr`=0x200.
- `id_redirect` to 0x100 together with `stall`=1 in PRESENT:
  - `if_valid`=0 next cycle.
  - Request at 0x100 issued despite the stall.
- Next PC 0xFFFFFFFC+4:
  - `mem_addr` wraps to 0x0.
- `rst` pulse mid-WAIT, followed by a stray `mem_ack`:
  - Outputs return to reset values.
  - Stray ack is ignored.
